// File: rtl/rf_controller.sv
// Sequencing controller for the 32-entry register-file datapath: read, execute, write back.
// Locked-destination write-backs are suppressed, and a stalled execution unit is aborted after TIMEOUT cycles.
module rf_controller #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             dpclk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [4:0]       instr_rs1,
    input  logic [4:0]       instr_rs2,
    input  logic [4:0]       instr_rd,
    input  logic             instr_wb,
    output logic [4:0]       read_sel_1,
    output logic [4:0]       read_sel_2,
    output logic [4:0]       write_sel,
    output logic             out_en_1,
    output logic             out_en_2,
    output logic             write,
    output logic             exec_start,
    input  logic             exec_done,
    input  logic [31:0]      lock_mask,
    output logic             busy,
    output logic             retire,
    output logic             wr_violation,
    output logic             exec_timeout,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state;
    logic       wb_q;
    logic [7:0] exec_cnt;

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    always_ff @(posedge dpclk) begin
        if (rst) begin
            state        <= IDLE;
            wb_q         <= 1'b0;
            exec_cnt     <= '0;
            read_sel_1   <= '0;
            read_sel_2   <= '0;
            write_sel    <= '0;
            out_en_1     <= 1'b0;
            out_en_2     <= 1'b0;
            write        <= 1'b0;
            exec_start   <= 1'b0;
            retire       <= 1'b0;
            wr_violation <= 1'b0;
            exec_timeout <= 1'b0;
            retire_count <= '0;
        end else begin
            exec_start   <= 1'b0;
            write        <= 1'b0;
            retire       <= 1'b0;
            wr_violation <= 1'b0;
            exec_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        read_sel_1 <= instr_rs1;
                        read_sel_2 <= instr_rs2;
                        write_sel  <= instr_rd;
                        wb_q       <= instr_wb;
                        exec_start <= 1'b1;
                        out_en_1   <= 1'b1;
                        out_en_2   <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    exec_cnt <= '0;
                    state    <= EXEC;
                end
                EXEC: begin
                    // Completion wins over the timeout check in the last allowed cycle.
                    if (exec_done) begin
                        out_en_1 <= 1'b0;
                        out_en_2 <= 1'b0;
                        if (!wb_q) begin
                            retire       <= 1'b1;
                            retire_count <= retire_count + 1'b1;
                            state        <= IDLE;
                        end else if (lock_mask[write_sel]) begin
                            wr_violation <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            write <= 1'b1;
                            state <= WB;
                        end
                    end else if (exec_cnt == LAST_CNT) begin
                        out_en_1     <= 1'b0;
                        out_en_2     <= 1'b0;
                        exec_timeout <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        exec_cnt <= exec_cnt + 1'b1;
                    end
                end
                WB: begin
                    retire       <= 1'b1;
                    retire_count <= retire_count + 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
